// File: rtl/gpr_wport_arb_if.sv
// Bus bundle between the WB/MC/ID pipeline side and the GPR write-port arbiter.
// The arbiter uses the slave modport; the pipeline side (or a testbench) uses master.
interface gpr_wport_arb_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              wb_we_i;
    logic [ADDR_W-1:0] wb_wa_i;
    logic [DATA_W-1:0] wb_wd_i;
    logic              mc_issue_i;
    logic [ADDR_W-1:0] mc_issue_rd_i;
    logic              mc_valid_i;
    logic [ADDR_W-1:0] mc_wa_i;
    logic [DATA_W-1:0] mc_wd_i;
    logic              mc_ready_o;
    logic [ADDR_W-1:0] id_rs1_i;
    logic [ADDR_W-1:0] id_rs2_i;
    logic [ADDR_W-1:0] id_rd_i;
    logic              hazard_o;
    logic              stall_o;
    logic              rd_we_o;
    logic [ADDR_W-1:0] rd_wa_o;
    logic [DATA_W-1:0] rd_wd_o;

    modport master (
        output wb_we_i, wb_wa_i, wb_wd_i,
        output mc_issue_i, mc_issue_rd_i,
        output mc_valid_i, mc_wa_i, mc_wd_i,
        output id_rs1_i, id_rs2_i, id_rd_i,
        input  mc_ready_o, hazard_o, stall_o,
        input  rd_we_o, rd_wa_o, rd_wd_o
    );

    modport slave (
        input  wb_we_i, wb_wa_i, wb_wd_i,
        input  mc_issue_i, mc_issue_rd_i,
        input  mc_valid_i, mc_wa_i, mc_wd_i,
        input  id_rs1_i, id_rs2_i, id_rd_i,
        output mc_ready_o, hazard_o, stall_o,
        output rd_we_o, rd_wa_o, rd_wd_o
    );
endinterface

// File: rtl/gpr_wport_arb.sv
// GPR write-port arbiter: WB always wins the single regfile write port; long-latency
// (MC) results park in a 1-entry buffer and drain on WB-idle cycles. A busy scoreboard
// of outstanding MC destinations lets ID stall on RAW/WAW.
// Optional feature macro: GPR_ARB_STARVE_EN enables the starvation counter, the FORCE
// state and stall_o; without it stall_o is tied low and MC waits for a WB-idle cycle.
module gpr_wport_arb #(
    parameter int unsigned REG_NUM    = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic           ck_i,
    input  logic           rs_i,
    gpr_wport_arb_if.slave bus
);

    if (REG_NUM != (1 << ADDR_W)) begin : gBadRegNum
        $error("gpr_wport_arb: REG_NUM must equal 2**ADDR_W");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : gBadStarve
        $error("gpr_wport_arb: STARVE_MAX must be in 1..255");
    end

    // IDLE means the buffer is empty; HELD/FORCE both mean it holds a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        FORCE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] bufWa_q;
    logic [DATA_W-1:0] bufWd_q;
    logic [REG_NUM-1:0] busy_q, busy_d;
    logic [REG_NUM-1:0] drainMask, busyEff;

    logic wbAct;
    logic bufFull;
    logic drain;
    logic capture;

    assign wbAct   = bus.wb_we_i & (bus.wb_wa_i != '0);
    assign bufFull = (state_q != IDLE);
    assign drain   = bufFull & ~wbAct;
    // A result to x0 is accepted by the handshake but never stored.
    assign capture = bus.mc_valid_i & ~bufFull & (bus.mc_wa_i != '0);

`ifdef GPR_ARB_STARVE_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starveCnt_q, starveCnt_d;

    // Count cycles the held result is blocked by WB; cleared whenever the buffer drains.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (drain) begin
            starveCnt_d = 8'd0;
        end else if (state_q == HELD && wbAct && starveCnt_q != 8'hFF) begin
            starveCnt_d = starveCnt_q + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            starveCnt_q <= 8'd0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: fill on capture, empty on drain, escalate to FORCE when starved.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = HELD;
                end
            end
            HELD: begin
                if (drain) begin
                    state_d = IDLE;
                end
`ifdef GPR_ARB_STARVE_EN
                else if (starveCnt_d >= STARVE_LIM) begin
                    state_d = FORCE;
                end
`endif
            end
            FORCE: begin
                if (drain) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake, bubble request and the combinational write-port mux.
    always_comb begin
        bus.mc_ready_o = (state_q == IDLE);
        bus.stall_o    = 1'b0;
`ifdef GPR_ARB_STARVE_EN
        bus.stall_o    = (state_q == FORCE);
`endif
        bus.rd_we_o = 1'b0;
        bus.rd_wa_o = '0;
        bus.rd_wd_o = '0;
        if (wbAct) begin
            bus.rd_we_o = 1'b1;
            bus.rd_wa_o = bus.wb_wa_i;
            bus.rd_wd_o = bus.wb_wd_i;
        end else if (bufFull) begin
            bus.rd_we_o = 1'b1;
            bus.rd_wa_o = bufWa_q;
            bus.rd_wd_o = bufWd_q;
        end
    end

    // Result buffer payload, loaded only on an accepted non-x0 MC result.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            bufWa_q <= '0;
            bufWd_q <= '0;
        end else if (capture) begin
            bufWa_q <= bus.mc_wa_i;
            bufWd_q <= bus.mc_wd_i;
        end
    end

    // Scoreboard next state: clear the drained reg first so a same-cycle issue re-sets it.
    always_comb begin
        busy_d = busy_q;
        if (drain) begin
            busy_d[bufWa_q] = 1'b0;
        end
        if (bus.mc_issue_i && bus.mc_issue_rd_i != '0) begin
            busy_d[bus.mc_issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge ck_i or posedge rs_i) begin
        if (rs_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Hide the reg being drained now (regfile bypasses it) and never flag x0.
    always_comb begin
        drainMask = '0;
        if (drain) begin
            drainMask[bufWa_q] = 1'b1;
        end
        busyEff    = busy_q & ~drainMask;
        busyEff[0] = 1'b0;
    end

    assign bus.hazard_o = busyEff[bus.id_rs1_i] | busyEff[bus.id_rs2_i] | busyEff[bus.id_rd_i];

endmodule

// File: tb/tb_gpr_wport_arb.sv
// Self-checking bench for gpr_wport_arb: expected regfile writes go into a queue as
// stimulus is applied; a monitor pops one entry per rd_we_o cycle. Status outputs are
// checked per cycle against hand-computed values.
module tb_gpr_wport_arb;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
`ifdef GPR_ARB_STARVE_EN
    localparam logic StarveOn = 1'b1;
`else
    localparam logic StarveOn = 1'b0;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
    } wr_t;

    logic ck = 1'b0;
    logic rs = 1'b1;
    int   assertCount = 0;
    int   failCount = 0;
    wr_t  expQ[$];
    wr_t  monExp;

    gpr_wport_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    gpr_wport_arb #(
        .REG_NUM(32),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_MAX(8)
    ) dut (
        .ck_i(ck),
        .rs_i(rs),
        .bus(bus)
    );

    always #5 ck = ~ck;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic wbWe, input logic [4:0] wbWa, input logic [31:0] wbWd,
                                 input logic mcValid, input logic [4:0] mcWa, input logic [31:0] mcWd,
                                 input logic mcIssue, input logic [4:0] issueRd);
        bus.wb_we_i       = wbWe;
        bus.wb_wa_i       = wbWa;
        bus.wb_wd_i       = wbWd;
        bus.mc_valid_i    = mcValid;
        bus.mc_wa_i       = mcWa;
        bus.mc_wd_i       = mcWd;
        bus.mc_issue_i    = mcIssue;
        bus.mc_issue_rd_i = issueRd;
    endtask

    task automatic setId(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        bus.id_rs1_i = rs1;
        bus.id_rs2_i = rs2;
        bus.id_rd_i  = rd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    endtask

    task automatic nextCycle();
        @(posedge ck);
        #1;
    endtask

    task automatic sample();
        @(negedge ck);
    endtask

    task automatic expectWrite(input logic [4:0] wa, input logic [31:0] wd);
        expQ.push_back(wr_t'{wa: wa, wd: wd});
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_mc_ready"}, 32'(bus.mc_ready_o), 32'd1);
        checkOutput({tag, "_hazard"},   32'(bus.hazard_o),   32'd0);
        checkOutput({tag, "_stall"},    32'(bus.stall_o),    32'd0);
        checkOutput({tag, "_rd_we"},    32'(bus.rd_we_o),    32'd0);
        checkOutput({tag, "_rd_wa"},    32'(bus.rd_wa_o),    32'd0);
        checkOutput({tag, "_rd_wd"},    bus.rd_wd_o,         32'd0);
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge ck) begin
        if (!rs && bus.rd_we_o) begin
            assertCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpected_write: got wa=%0d wd=0x%0h, expected no write",
                         bus.rd_wa_o, bus.rd_wd_o);
            end else begin
                monExp = expQ.pop_front();
                if (bus.rd_wa_o !== monExp.wa || bus.rd_wd_o !== monExp.wd) begin
                    failCount++;
                    $display("[TB] FAIL write_port: got wa=%0d wd=0x%0h, expected wa=%0d wd=0x%0h",
                             bus.rd_wa_o, bus.rd_wd_o, monExp.wa, monExp.wd);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        setId(5'd0, 5'd0, 5'd0);
        rs = 1'b1;
        sample();
        sample();
        checkResetValues("reset");
        @(posedge ck);
        #1;
        rs = 1'b0;

        // Capture x5 with WB idle, drain next cycle
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        sample();
        checkOutput("capture_ready", 32'(bus.mc_ready_o), 32'd1);
        checkOutput("capture_no_we", 32'(bus.rd_we_o), 32'd0);
        nextCycle();
        idle();
        expectWrite(5'd5, 32'hDEADBEEF);
        sample();
        checkOutput("drain_we", 32'(bus.rd_we_o), 32'd1);
        checkOutput("drain_ready", 32'(bus.mc_ready_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("after_drain_ready", 32'(bus.mc_ready_o), 32'd1);
        checkOutput("after_drain_we", 32'(bus.rd_we_o), 32'd0);

        // WB priority: x7 held while WB writes x3 three times
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_0777, 1'b0, 5'd0);
        setId(5'd0, 5'd0, 5'd7);
        sample();
        checkOutput("x7_busy_hazard", 32'(bus.hazard_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            applyStimulus(1'b1, 5'd3, 32'h3000_0000 + 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            expectWrite(5'd3, 32'h3000_0000 + 32'(k));
            sample();
            checkOutput("wb_prio_ready", 32'(bus.mc_ready_o), 32'd0);
            checkOutput("wb_prio_hazard", 32'(bus.hazard_o), 32'd1);
        end
        nextCycle();
        idle();
        expectWrite(5'd7, 32'h0000_0777);
        sample();
        checkOutput("x7_drain_hazard", 32'(bus.hazard_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("x7_cleared_hazard", 32'(bus.hazard_o), 32'd0);
        checkOutput("x7_cleared_ready", 32'(bus.mc_ready_o), 32'd1);
        setId(5'd0, 5'd0, 5'd0);

        // Hazard tracking on x9, including set-wins on same-cycle drain and issue
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        setId(5'd0, 5'd9, 5'd0);
        sample();
        checkOutput("issue_cycle_hazard", 32'(bus.hazard_o), 32'd0);
        nextCycle();
        idle();
        sample();
        checkOutput("rs2_busy_hazard", 32'(bus.hazard_o), 32'd1);
        nextCycle();
        setId(5'd0, 5'd0, 5'd0);
        sample();
        checkOutput("rs1_zero_hazard", 32'(bus.hazard_o), 32'd0);
        nextCycle();
        setId(5'd0, 5'd9, 5'd0);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0001, 1'b0, 5'd0);
        sample();
        checkOutput("x9_capture_hazard", 32'(bus.hazard_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
        expectWrite(5'd9, 32'h9999_0001);
        sample();
        checkOutput("x9_drain_hazard", 32'(bus.hazard_o), 32'd0);
        nextCycle();
        idle();
        sample();
        checkOutput("set_wins_hazard", 32'(bus.hazard_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h9999_0002, 1'b0, 5'd0);
        nextCycle();
        idle();
        expectWrite(5'd9, 32'h9999_0002);
        nextCycle();
        sample();
        checkOutput("x9_final_hazard", 32'(bus.hazard_o), 32'd0);
        setId(5'd0, 5'd0, 5'd0);

        // MC result to x0 is accepted and dropped
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0);
        sample();
        checkOutput("x0_ready", 32'(bus.mc_ready_o), 32'd1);
        checkOutput("x0_no_we", 32'(bus.rd_we_o), 32'd0);
        nextCycle();
        idle();
        sample();
        checkOutput("x0_ready_next", 32'(bus.mc_ready_o), 32'd1);
        checkOutput("x0_no_we_next", 32'(bus.rd_we_o), 32'd0);

        // WB write to x0 does not block a drain
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'h00C0_FFEE, 1'b0, 5'd0);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 32'hBAD0_BAD0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        expectWrite(5'd12, 32'h00C0_FFEE);
        sample();
        checkOutput("wbx0_drain_wa", 32'(bus.rd_wa_o), 32'd12);
        nextCycle();
        idle();
        sample();
        checkOutput("wbx0_after_ready", 32'(bus.mc_ready_o), 32'd1);

        // Starvation: x20 held while WB is busy for 9 cycles
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hABCD_1234, 1'b0, 5'd0);
        for (int k = 1; k <= 8; k++) begin
            nextCycle();
            applyStimulus(1'b1, 5'd1, 32'(k), 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
            expectWrite(5'd1, 32'(k));
            sample();
            checkOutput("starve_stall_pre", 32'(bus.stall_o), 32'd0);
        end
        nextCycle();
        applyStimulus(1'b1, 5'd1, 32'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        expectWrite(5'd1, 32'd9);
        sample();
        checkOutput("starve_stall_force", 32'(bus.stall_o), 32'(StarveOn));
        nextCycle();
        idle();
        expectWrite(5'd20, 32'hABCD_1234);
        sample();
        checkOutput("starve_stall_drain", 32'(bus.stall_o), 32'(StarveOn));
        checkOutput("starve_drain_we", 32'(bus.rd_we_o), 32'd1);
        nextCycle();
        sample();
        checkOutput("starve_stall_after", 32'(bus.stall_o), 32'd0);
        checkOutput("starve_ready_after", 32'(bus.mc_ready_o), 32'd1);

        // Reset mid-run with the buffer full and x15 busy
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd15);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd15, 32'h5555_AAAA, 1'b0, 5'd0);
        setId(5'd15, 5'd0, 5'd0);
        sample();
        checkOutput("pre_reset_hazard", 32'(bus.hazard_o), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        expectWrite(5'd2, 32'h22);
        sample();
        checkOutput("pre_reset_ready", 32'(bus.mc_ready_o), 32'd0);
        nextCycle();
        idle();
        rs = 1'b1;
        sample();
        checkResetValues("midreset");
        @(posedge ck);
        #1;
        rs = 1'b0;
        sample();
        checkOutput("post_reset_ready", 32'(bus.mc_ready_o), 32'd1);
        checkOutput("post_reset_hazard", 32'(bus.hazard_o), 32'd0);
        checkOutput("post_reset_we", 32'(bus.rd_we_o), 32'd0);
        nextCycle();
        sample();
        checkOutput("post_reset_we_next", 32'(bus.rd_we_o), 32'd0);
        setId(5'd0, 5'd0, 5'd0);

        checkOutput("pending_writes", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
